// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: shared state, source and op types for the L2 arbiter
package rv32i_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;
  localparam int L2_LINE_WIDTH = 256;
endpackage

// File: rtl/l2_arb_req_reg.sv
// l2_arb_req_reg: captures the granted request so L2 inputs stay stable for the transaction
module l2_arb_req_reg
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = L2_LINE_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] next_address,
  input  logic [LINE_WIDTH-1:0] next_wdata,
  input  arb_op_t               next_op,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [LINE_WIDTH-1:0] wdata,
  output arb_op_t               op
);
  always_ff @(posedge clk)
    if (clear) begin
      address <= '0;
      wdata   <= '0;
      op      <= OP_READ;
    end else if (load) begin
      address <= next_address;
      wdata   <= next_wdata;
      op      <= next_op;
    end
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin arbiter sharing the L2 cache between the L1 I-cache and D-cache
module l2_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = L2_LINE_WIDTH,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [31:0]           i_grant_count,
  output logic [31:0]           d_grant_count
);
  arb_state_t state;
  arb_src_t   last_grant;
  arb_op_t    op;
  logic       d_req, grant_i, grant_d, d_wr_grant;
  assign d_req      = d_read | d_write;
  // On a tie, the side that was not granted last wins
  assign grant_i    = state == IDLE && i_read && (!d_req || last_grant == SRC_D);
  assign grant_d    = state == IDLE && d_req && (!i_read || last_grant == SRC_I);
  assign d_wr_grant = grant_d && d_write;
  l2_arb_req_reg #(.LINE_WIDTH(LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_req (
    .clk          (clk),
    .clear        (rst),
    .load         (grant_i | grant_d),
    .next_address (grant_d ? d_address : i_address),
    .next_wdata   (d_wr_grant ? d_wdata : '0),
    .next_op      (d_wr_grant ? OP_WRITE : OP_READ),
    .address      (l2_address),
    .wdata        (l2_wdata),
    .op           (op)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      last_grant    <= SRC_I;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else if (grant_i) begin
      state         <= SERVE_I;
      last_grant    <= SRC_I;
      i_grant_count <= i_grant_count + 32'd1;
    end else if (grant_d) begin
      state         <= SERVE_D;
      last_grant    <= SRC_D;
      d_grant_count <= d_grant_count + 32'd1;
    end else if (state != IDLE && l2_resp) begin
      state <= IDLE;
    end
  assign l2_read  = state != IDLE && op == OP_READ;
  assign l2_write = state != IDLE && op == OP_WRITE;
  // A response arriving while reset is applied belongs to an abandoned transaction
  assign i_resp   = state == SERVE_I && l2_resp && !rst;
  assign d_resp   = state == SERVE_D && l2_resp && !rst;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench with an L2 latency model and auto-requesters
module tb_l2_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  logic clk = 0, rst = 1, i_read = 0, d_read = 0, d_write = 0, l2_resp = 0;
  logic [AW-1:0] i_address = '0, d_address = '0, l2_address;
  logic [LW-1:0] d_wdata = '0, l2_rdata = '0, i_rdata, d_rdata, l2_wdata;
  logic i_resp, d_resp, l2_read, l2_write;
  logic [31:0] i_grant_count, d_grant_count;
  int passed = 0, total = 0;
  int l2_lat = 1, cnt = 0, i_auto = 0, d_auto = 0;
  bit auto_mode = 0;
  logic i_resp_s = 0, d_resp_s = 0;
  logic [LW-1:0] l2_data = '0;
  typedef struct {
    logic          is_d;
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  l2_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );

  // Monitor pops the scoreboard on every resp; L2 model and auto-requesters update after each edge
  initial forever begin
    @(negedge clk);
    i_resp_s = i_resp;
    d_resp_s = d_resp;
    if (i_resp || d_resp) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: resp i=%b d=%b, none expected", i_resp, d_resp);
      end else begin
        mon_e = sb.pop_front();
        total++;
        if ({i_resp, d_resp} !== (mon_e.is_d ? 2'b01 : 2'b10))
          $display("FAIL sb_src: got i/d resp %b%b want is_d=%b", i_resp, d_resp, mon_e.is_d);
        else passed++;
        total++;
        if (l2_address !== mon_e.addr)
          $display("FAIL sb_addr: got %h want %h", l2_address, mon_e.addr);
        else passed++;
        total++;
        if ({l2_read, l2_write} !== {!mon_e.wr, mon_e.wr})
          $display("FAIL sb_op: got rd/wr %b%b want wr=%b", l2_read, l2_write, mon_e.wr);
        else passed++;
        total++;
        if (l2_wdata !== mon_e.wdata)
          $display("FAIL sb_wdata: got %h want %h", l2_wdata, mon_e.wdata);
        else passed++;
        total++;
        if ((i_resp ? i_rdata : d_rdata) !== mon_e.rdata)
          $display("FAIL sb_rdata: got %h want %h", i_resp ? i_rdata : d_rdata, mon_e.rdata);
        else passed++;
      end
    end
    @(posedge clk);
    #1;
    cnt = (l2_read | l2_write) ? cnt + 1 : 0;
    l2_resp = cnt == l2_lat + 1;
    l2_rdata = l2_data;
    if (auto_mode) begin
      if (i_read && i_resp_s) i_read = 0;
      else if (!i_read && i_auto > 0) begin i_read = 1; i_auto--; end
      if (d_read && d_resp_s) d_read = 0;
      else if (!d_read && d_auto > 0) begin d_read = 1; d_auto--; end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask

  task automatic push_exp(input logic is_d, input logic [AW-1:0] addr, input logic wr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    exp_t e;
    e = '{is_d, addr, wr, wdata, rdata};
    sb.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1;
    tick;
    @(negedge clk);
    total++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0)
      $display("FAIL reset_ctl: got %b want 0000", {l2_read, l2_write, i_resp, d_resp});
    else passed++;
    total++;
    if (l2_address !== '0) $display("FAIL reset_addr: got %h want 0", l2_address);
    else passed++;
    total++;
    if (l2_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", l2_wdata);
    else passed++;
    total++;
    if ({i_grant_count, d_grant_count} !== 64'd0)
      $display("FAIL reset_counts: got %0d/%0d want 0/0", i_grant_count, d_grant_count);
    else passed++;
    tick;
    rst = 0;
  endtask

  task automatic test_i_fill;
    l2_lat = 5;
    l2_data = {32{8'hA5}};
    push_exp(1'b0, 32'h1000, 1'b0, {LW{1'b0}}, {32{8'hA5}});
    tick;
    i_read = 1;
    i_address = 32'h1000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (l2_read !== (c >= 1 && c <= 6)) $display("FAIL i_fill_l2_read c=%0d: got %b", c, l2_read);
      else passed++;
      total++;
      if (i_resp !== (c == 6)) $display("FAIL i_fill_resp c=%0d: got %b", c, i_resp);
      else passed++;
      if (c == 6) begin
        total++;
        if (i_rdata !== {32{8'hA5}}) $display("FAIL i_fill_rdata: got %h want a5..a5", i_rdata);
        else passed++;
      end
      tick;
      if (c == 6) i_read = 0;
    end
    total++;
    if (i_grant_count !== 32'd1 || d_grant_count !== 32'd0)
      $display("FAIL i_fill_counts: got %0d/%0d want 1/0", i_grant_count, d_grant_count);
    else passed++;
  endtask

  task automatic test_d_writeback;
    logic [LW-1:0] wd;
    int pulses;
    wd = {8{32'h1234_5678}};
    pulses = 0;
    l2_lat = 3;
    l2_data = {8{32'hCAFE_F00D}};
    push_exp(1'b1, 32'h8000_0040, 1'b1, wd, {8{32'hCAFE_F00D}});
    tick;
    d_write = 1;
    d_address = 32'h8000_0040;
    d_wdata = wd;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (l2_write !== (c >= 1 && c <= 4)) $display("FAIL d_wb_l2_write c=%0d: got %b", c, l2_write);
      else passed++;
      total++;
      if (l2_read !== 1'b0) $display("FAIL d_wb_l2_read c=%0d: got %b want 0", c, l2_read);
      else passed++;
      if (c == 1) begin
        total++;
        if (l2_wdata !== wd) $display("FAIL d_wb_wdata: got %h want %h", l2_wdata, wd);
        else passed++;
      end
      if (d_resp) pulses++;
      tick;
      if (c == 4) d_write = 0;
    end
    total++;
    if (pulses !== 1) $display("FAIL d_wb_pulses: got %0d want 1", pulses);
    else passed++;
    total++;
    if (d_grant_count !== 32'd1) $display("FAIL d_wb_count: got %0d want 1", d_grant_count);
    else passed++;
  endtask

  task automatic test_tie;
    apply_reset;
    l2_lat = 2;
    l2_data = {16{16'h5A5A}};
    push_exp(1'b1, 32'h3000, 1'b0, {LW{1'b0}}, {16{16'h5A5A}});
    push_exp(1'b0, 32'h2000, 1'b0, {LW{1'b0}}, {16{16'h5A5A}});
    tick;
    i_read = 1;
    d_read = 1;
    i_address = 32'h2000;
    d_address = 32'h3000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (l2_read !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)))
        $display("FAIL tie_l2_read c=%0d: got %b", c, l2_read);
      else passed++;
      total++;
      if ({i_resp, d_resp} !== {c == 7, c == 3})
        $display("FAIL tie_resp c=%0d: got i/d %b%b", c, i_resp, d_resp);
      else passed++;
      if (c == 1 || c == 5) begin
        total++;
        if (l2_address !== (c == 1 ? 32'h3000 : 32'h2000))
          $display("FAIL tie_addr c=%0d: got %h", c, l2_address);
        else passed++;
      end
      tick;
      if (c == 3) d_read = 0;
      if (c == 7) i_read = 0;
    end
    total++;
    if (i_grant_count !== 32'd1 || d_grant_count !== 32'd1)
      $display("FAIL tie_counts: got %0d/%0d want 1/1", i_grant_count, d_grant_count);
    else passed++;
  endtask

  task automatic test_fairness;
    bit done;
    apply_reset;
    l2_lat = 1;
    l2_data = {4{64'h0123_4567_89AB_CDEF}};
    i_address = 32'h4000;
    d_address = 32'h5000;
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b1, 32'h5000, 1'b0, {LW{1'b0}}, {4{64'h0123_4567_89AB_CDEF}});
      push_exp(1'b0, 32'h4000, 1'b0, {LW{1'b0}}, {4{64'h0123_4567_89AB_CDEF}});
    end
    i_auto = 4;
    d_auto = 4;
    auto_mode = 1;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      tick;
      done = i_auto == 0 && d_auto == 0 && !i_read && !d_read;
    end
    auto_mode = 0;
    total++;
    if (!done) $display("FAIL fair_timeout: got unfinished want done within 200 cycles");
    else passed++;
    total++;
    if (i_grant_count !== 32'd4 || d_grant_count !== 32'd4)
      $display("FAIL fair_counts: got %0d/%0d want 4/4", i_grant_count, d_grant_count);
    else passed++;
  endtask

  task automatic test_stability;
    l2_lat = 4;
    l2_data = {8{32'h0BAD_F00D}};
    d_wdata = '0;
    push_exp(1'b1, 32'h6000, 1'b0, {LW{1'b0}}, {8{32'h0BAD_F00D}});
    tick;
    d_read = 1;
    d_address = 32'h6000;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        total++;
        if (l2_address !== 32'h6000) $display("FAIL stab_addr c=%0d: got %h want 6000", c, l2_address);
        else passed++;
      end
      total++;
      if (d_resp !== (c == 5)) $display("FAIL stab_resp c=%0d: got %b", c, d_resp);
      else passed++;
      tick;
      if (c == 0) begin
        d_address = 32'h7777_0000;
        d_wdata = {LW{1'b1}};
      end
      if (c == 5) d_read = 0;
    end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    l2_lat = 20;
    tick;
    i_read = 1;
    i_address = 32'h9000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        total++;
        if (l2_read !== (c >= 1)) $display("FAIL rmid_l2_read c=%0d: got %b", c, l2_read);
        else passed++;
      end
      if (c == 4) begin
        total++;
        if (l2_read !== 1'b0) $display("FAIL rmid_idle: got l2_read %b want 0", l2_read);
        else passed++;
        total++;
        if (i_resp !== 1'b0) $display("FAIL rmid_iresp: got %b want 0", i_resp);
        else passed++;
        total++;
        if (i_grant_count !== 32'd0 || d_grant_count !== 32'd0)
          $display("FAIL rmid_counts: got %0d/%0d want 0/0", i_grant_count, d_grant_count);
        else passed++;
      end
      tick;
      if (c == 2) rst = 1;
      if (c == 3) begin
        rst = 0;
        i_read = 0;
        l2_resp = 1;
      end
    end
  endtask

  initial begin
    test_reset;
    test_i_fill;
    test_d_writeback;
    test_tie;
    test_fairness;
    test_stability;
    test_reset_mid;
    total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
